uart_buffered_core: RTL and testbench

UART_BUFFERED_CORE -- requirements
Module: uart_buffered_core

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_buffered_core_if.sv | 16 +
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_buffered_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_buffered_core.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared state encodings and default parameter values for the buffered UART.
package uart_pkg;

    localparam int DEF_CLK_PER_TICK = 7;
    localparam int DEF_OVERSAMPLE   = 8;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_FIFO_DEPTH   = 16;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_buffered_core_if.sv
// Push/pop handshake bundle for one FIFO: master is the producer/consumer, slave is the FIFO.
interface uart_buffered_core_if #(parameter int W = 8) ();

    logic [W-1:0] push_data;
    logic         push_valid;
    logic         push_ready;
    logic [W-1:0] pop_data;
    logic         pop_valid;
    logic         pop_ready;

    modport master (output push_data, push_valid, pop_ready,
                    input  push_ready, pop_data, pop_valid);
    modport slave  (input  push_data, push_valid, pop_ready,
                    output push_ready, pop_data, pop_valid);

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO; pointers carry one extra wrap bit.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    uart_buffered_core_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Equal indices: same wrap bit means empty, differing wrap bit means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign bus.push_ready = !full;
    assign bus.pop_valid  = !empty;
    assign bus.pop_data   = mem[rd_ptr[AW-1:0]];

    assign do_push = bus.push_valid && !full;
    assign do_pop  = bus.pop_ready && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= bus.push_data;
    end

endmodule

// File: rtl/uart_buffered_core.sv
// Oversampling UART with TX and RX FIFOs on one clock.
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_buffered_core
    import uart_pkg::*;
#(
    parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                 clk_uart,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 tx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_overrun
);
    localparam int TW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int OW = $clog2(OVERSAMPLE);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(CLK_PER_TICK-1));

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    uart_buffered_core_if #(.W(DATA_BITS)) tx_bus ();
    uart_buffered_core_if #(.W(DATA_BITS)) rx_bus ();

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk_uart), .rst(rst), .bus(tx_bus.slave));
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk_uart), .rst(rst), .bus(rx_bus.slave));

    assign tx_bus.push_data  = tx_data;
    assign tx_bus.push_valid = tx_valid;
    assign tx_ready          = tx_bus.push_ready;

    logic [2:0]           tx_state;
    logic [OW-1:0]        tx_os;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit_end;
    logic                 tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = tick && (tx_os == OW'(OVERSAMPLE-1));
    // A queued byte starts either from idle or straight out of the stop bit.
    assign tx_load = tx_bus.pop_valid &&
                     ((tx_state == TX_IDLE && tick) || (tx_state == TX_STOP && tx_bit_end));
    assign tx_bus.pop_ready = tx_load;
    assign tx_busy = (tx_state != TX_IDLE) || tx_bus.pop_valid;

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_os    <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_load) begin
            tx_state <= TX_START;
            tx_os    <= '0;
            tx_shift <= tx_bus.pop_data;
            tx       <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_bus.pop_data;
`endif
        end else if (tx_state != TX_IDLE && tick) begin
            tx_os <= tx_bit_end ? '0 : tx_os + OW'(1);
            if (tx_bit_end) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == 4'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                            tx_state <= TX_PARITY;
                            tx       <= tx_par;
`else
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end
`endif
                    default: begin
                        tx_state <= TX_IDLE;
                        tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    logic [2:0]           rx_state;
    logic [OW-1:0]        rx_os;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_half;
    logic                 rx_full_bit;
    logic                 par_ok;

    assign rx_half     = tick && (rx_os == OW'(OVERSAMPLE/2-1));
    assign rx_full_bit = tick && (rx_os == OW'(OVERSAMPLE-1));

`ifdef UART_PARITY_EN
    logic rx_par_bad;
    assign par_ok = !rx_par_bad;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign rx_bus.push_valid = (rx_state == RX_STOP) && rx_full_bit && rx_sync && par_ok;
    assign rx_bus.push_data  = rx_shift;
    assign rx_bus.pop_ready  = rx_ready;
    assign rx_valid          = rx_bus.pop_valid;
    assign rx_data           = rx_bus.pop_valid ? rx_bus.pop_data : '0;

    // Start is re-checked half a bit in; every later sample lands mid-bit.
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_os      <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_os    <= '0;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_os    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else if (tick) begin
                        rx_os <= rx_os + OW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_full_bit) begin
                        rx_os    <= '0;
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end else if (tick) begin
                        rx_os <= rx_os + OW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_full_bit) begin
                        rx_os      <= '0;
                        rx_par_bad <= (rx_sync != ^rx_shift);
                        rx_state   <= RX_STOP;
                    end else if (tick) begin
                        rx_os <= rx_os + OW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_full_bit) begin
                        rx_os <= '0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HIGH;
                        end else begin
                            rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
                            parity_err <= rx_par_bad;
                            rx_overrun <= !rx_par_bad && !rx_bus.push_ready;
`else
                            rx_overrun <= !rx_bus.push_ready;
`endif
                        end
                    end else if (tick) begin
                        rx_os <= rx_os + OW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buffered_core.sv
// Directed self-checking bench for uart_buffered_core (default parameters, 56 clocks per bit).
module tb_uart_buffered_core;

    localparam int CLK_PERIOD = 10;
    localparam int BIT_CYC    = 56;
    localparam int BIT_T      = BIT_CYC * CLK_PERIOD;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk_uart = 1'b0;
    logic rst;
    logic rx_drv;
    logic loop_en;
    logic tx_w;
    logic rx_line;
    logic tx_busy;
    logic frame_err;
    logic parity_err;
    logic rx_overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;

    uart_buffered_core_if #(.W(8)) host ();

    always #(CLK_PERIOD/2) clk_uart = ~clk_uart;

    assign rx_line = loop_en ? tx_w : rx_drv;

    uart_buffered_core dut (
        .clk_uart   (clk_uart),
        .rst        (rst),
        .rx         (rx_line),
        .tx         (tx_w),
        .tx_data    (host.push_data),
        .tx_valid   (host.push_valid),
        .tx_ready   (host.push_ready),
        .rx_data    (host.pop_data),
        .rx_valid   (host.pop_valid),
        .rx_ready   (host.pop_ready),
        .tx_busy    (tx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_overrun (rx_overrun)
    );

    // Tally every error pulse so tests can compare before/after counts.
    always @(posedge clk_uart) begin
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (rx_overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_uart);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        host.push_data  = b;
        host.push_valid = 1'b1;
        step(1);
        host.push_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        checkOutput({tag, "_valid"}, host.pop_valid, 1);
        checkOutput({tag, "_data"}, host.pop_data, exp);
        host.pop_ready = 1'b1;
        step(1);
        host.pop_ready = 1'b0;
    endtask

    task automatic wait_tx_fall(input string tag);
        int n = 0;
        while (tx_w !== 1'b0 && n < 300) begin
            step(1);
            n++;
        end
        checkOutput(tag, (tx_w === 1'b0), 1);
    endtask

`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Drives one serial frame on rx; the line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx_drv = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            #(BIT_T);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^data) ^ par_flip;
        #(BIT_T);
`endif
        rx_drv = stop_bit;
        #(BIT_T);
    endtask

    logic [10:0] a5_frame;
    logic [7:0]  ovr_vals [16];
    int fe0, pe0, ov0;

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
`ifdef UART_PARITY_EN
        a5_frame = 11'b10101001010;
`else
        a5_frame = 11'b00_1101001010;
`endif
        rst = 1'b1;
        rx_drv = 1'b1;
        loop_en = 1'b0;
        host.push_data = '0;
        host.push_valid = 1'b0;
        host.pop_ready = 1'b0;
        step(3);

        checkOutput("rst_tx", tx_w, 1);
        checkOutput("rst_tx_ready", host.push_ready, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_rx_valid", host.pop_valid, 0);
        checkOutput("rst_rx_data", host.pop_data, 0);
        checkOutput("rst_errs", {frame_err, parity_err, rx_overrun}, 0);
        #2 rst = 1'b0;
        step(2);

        // Single 0xA5 frame: exact start length, bit order, frame length.
        push_byte(8'hA5);
        wait_tx_fall("a5_start_seen");
        step(BIT_CYC-1);
        checkOutput("a5_start_last", tx_w, 0);
        step(1);
        checkOutput("a5_bit1_first", tx_w, a5_frame[1]);
        step(BIT_CYC/2);
        for (int i = 1; i < NBITS; i++) begin
            checkOutput($sformatf("a5_bit%0d", i), tx_w, a5_frame[i]);
            if (i < NBITS-1) step(BIT_CYC);
        end
        step(BIT_CYC/2 - 1);
        checkOutput("a5_busy_end", tx_busy, 1);
        step(1);
        checkOutput("a5_idle_busy", tx_busy, 0);
        checkOutput("a5_idle_tx", tx_w, 1);

        // Loopback of three back-to-back bytes.
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        loop_en = 1'b1;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h5A);
        wait_tx_fall("b2b_start_seen");
        step(BIT_CYC*NBITS - 1);
        checkOutput("b2b_stop1", tx_w, 1);
        step(1);
        checkOutput("b2b_start2", tx_w, 0);
        step(BIT_CYC*NBITS - 1);
        checkOutput("b2b_stop2", tx_w, 1);
        step(1);
        checkOutput("b2b_start3", tx_w, 0);
        step(BIT_CYC*NBITS + 60);
        loop_en = 1'b0;
        pop_check("b2b_rx0", 8'h00);
        pop_check("b2b_rx1", 8'hFF);
        pop_check("b2b_rx2", 8'h5A);
        checkOutput("b2b_rx_empty", host.pop_valid, 0);
        checkOutput("b2b_no_err", (fe_cnt-fe0) + (pe_cnt-pe0) + (ov_cnt-ov0), 0);

        // Low stop bit: one frame error, then no re-framing while rx stays low.
        fe0 = fe_cnt;
        applyStimulus(8'h3C, 1'b0);
        step(60);
        checkOutput("fe_pulse", fe_cnt - fe0, 1);
        checkOutput("fe_no_byte", host.pop_valid, 0);
        step(BIT_CYC*NBITS*2);
        checkOutput("fe_hold_low", fe_cnt - fe0, 1);
        checkOutput("fe_hold_no_byte", host.pop_valid, 0);
        rx_drv = 1'b1;
        step(BIT_CYC*2);
        applyStimulus(8'h96, 1'b1);
        step(BIT_CYC*2);
        pop_check("fe_recover", 8'h96);

        // 20-cycle glitch: ignored, receiver still usable.
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        rx_drv = 1'b0;
        #(20*CLK_PERIOD);
        rx_drv = 1'b1;
        step(BIT_CYC*NBITS);
        checkOutput("glitch_no_byte", host.pop_valid, 0);
        checkOutput("glitch_no_err", (fe_cnt-fe0) + (pe_cnt-pe0) + (ov_cnt-ov0), 0);
        applyStimulus(8'hC3, 1'b1);
        step(BIT_CYC*2);
        pop_check("glitch_recover", 8'hC3);

        // Fill the RX FIFO, overrun on the 17th frame, drain the first 16.
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) begin
            ovr_vals[i] = 8'h40 + 8'(i*9);
            applyStimulus(ovr_vals[i], 1'b1);
            step(20);
        end
        checkOutput("ovr_before", ov_cnt - ov0, 0);
        applyStimulus(8'hEE, 1'b1);
        step(20);
        checkOutput("ovr_pulse", ov_cnt - ov0, 1);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("ovr_pop%0d", i), ovr_vals[i]);
        end
        checkOutput("ovr_empty", host.pop_valid, 0);

        // Fill the TX FIFO, then reset in the middle of a frame.
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) push_byte(8'(i+1));
        checkOutput("tx_full_ready", host.push_ready, 0);
        wait_tx_fall("rst_frame_seen");
        step(10);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_tx", tx_w, 1);
        checkOutput("rst_mid_ready", host.push_ready, 1);
        checkOutput("rst_mid_busy", tx_busy, 0);
        #3 rst = 1'b0;
        step(BIT_CYC*NBITS*2);
        checkOutput("rst_after_tx", tx_w, 1);
        checkOutput("rst_after_busy", tx_busy, 0);
        checkOutput("rst_after_err", (fe_cnt-fe0) + (pe_cnt-pe0) + (ov_cnt-ov0), 0);

`ifdef UART_PARITY_EN
        // Flipped parity bit: one parity error, byte dropped.
        pe0 = pe_cnt;
        par_flip = 1'b1;
        applyStimulus(8'h3C, 1'b1);
        par_flip = 1'b0;
        step(60);
        checkOutput("par_pulse", pe_cnt - pe0, 1);
        checkOutput("par_no_byte", host.pop_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
